// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit scheduler.
package uart_pkg;

    // Number of byte requesters feeding the scheduler.
    localparam int NUM_REQ = 2;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } uart_tx_sched_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word fall-through byte FIFO. The head byte is visible on
// rdata whenever the FIFO is not empty. A push is still taken while full if a
// pop happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    // Pointer update; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter over two byte requesters feeding a FIFO,
// and an FSM that launches one byte at a time into a UART transmitter and
// waits for its done edge.
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to bound the WAIT_DONE
// state by TIMEOUT_CYCLES and report expiry on err_timeout_o.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int          DEPTH          = 8,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [8*NUM_REQ-1:0]     req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     tx_en_o,
    output logic [7:0]               tx_data_o,
    input  logic                     tx_done_i,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     err_timeout_o
);

    uart_tx_sched_state_e state;
    uart_tx_sched_state_e state_nx;

    logic               last_grant;   // 1: requester 1 was granted last
    logic               done_q;
    logic               done_edge;
    logic               timeout;
    logic [NUM_REQ-1:0] grant;
    logic               push;
    logic               pop;
    logic [7:0]         push_data;
    logic [7:0]         head;
    logic               full;
    logic               empty;

    // Round-robin grant: a lone requester wins; on contention the one not
    // granted last wins.
    always_comb begin
        grant = '0;
        case (req_valid_i)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    // The launch cycle frees a slot, so a full FIFO still accepts then.
    assign pop         = (state == LAUNCH);
    assign req_ready_o = (full && !pop) ? '0 : grant;
    assign push        = |(req_valid_i & req_ready_o);
    assign push_data   = req_ready_o[1] ? req_data_i[15:8] : req_data_i[7:0];
    assign done_edge   = tx_done_i && !done_q;
    assign busy_o      = !empty || (state != IDLE);

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    // Last-grant pointer moves only when a byte is actually accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= 1'b1;
        end else if (push) begin
            last_grant <= req_ready_o[1];
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [19:0] wait_cnt;

    // Cycle counter for WAIT_DONE, cleared during LAUNCH (the entry into WAIT_DONE).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (state == LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            wait_cnt <= wait_cnt + 20'd1;
        end
    end

    assign timeout = (state == WAIT_DONE) && !done_edge &&
                     (wait_cnt == TIMEOUT_CYCLES - 20'd1);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    assign err_timeout_o = timeout;

    // Next-state logic; a done level with no rising edge never completes a frame.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!empty && !tx_done_i) state_nx = LAUNCH;
            LAUNCH:    state_nx = WAIT_DONE;
            WAIT_DONE: if (done_edge || timeout) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // State and done-edge history registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= tx_done_i;
        end
    end

    // Launch outputs are registered on entry to LAUNCH; the byte is held afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_en_o   <= 1'b0;
            tx_data_o <= 8'h00;
        end else begin
            tx_en_o <= (state_nx == LAUNCH);
            if (state_nx == LAUNCH) tx_data_o <= head;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized bench for uart_tx_sched with a
// serialising UART transmitter model and a byte-level reference queue.
module tb_uart_tx_sched;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [3:0]  level;
    logic        err;

    logic        model_en = 1'b0;
    logic        man_done = 1'b0;
    logic        model_done = 1'b0;
    logic        ser = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int launches = 0;

    logic [7:0] expq[$];
    logic [7:0] rxq[$];
    int         mlast = 1;

    always #5 clk = ~clk;

    assign tx_done = model_en ? model_done : man_done;

    uart_tx_sched #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (20'd100)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ready_o   (ready),
        .tx_en_o       (tx_en),
        .tx_data_o     (tx_data),
        .tx_done_i     (tx_done),
        .busy_o        (busy),
        .level_o       (level),
        .err_timeout_o (err)
    );

    always @(posedge clk) if (tx_en) launches <= launches + 1;

    // UART transmitter model: 4 clocks per bit, 8N1, done high for 2 cycles.
    logic [9:0] tsh = '1;
    int tbits = 0;
    int tclk = 0;
    int tdone = 0;
    always @(posedge clk) begin
        model_done <= (tdone > 0);
        if (tdone > 0) tdone <= tdone - 1;
        if (tbits > 0) begin
            if (tclk == 3) begin
                tclk  <= 0;
                tsh   <= {1'b1, tsh[9:1]};
                ser   <= (tbits == 1) ? 1'b1 : tsh[1];
                tbits <= tbits - 1;
                if (tbits == 1) tdone <= 2;
            end else begin
                tclk <= tclk + 1;
            end
        end else if (tx_en) begin
            tsh   <= {1'b1, tx_data, 1'b0};
            ser   <= 1'b0;
            tbits <= 10;
            tclk  <= 0;
        end
    end

    // Serial receiver: samples each data bit mid-period.
    bit         ract = 1'b0;
    int         rcnt = 0;
    logic [7:0] rsh = '0;
    always @(posedge clk) begin
        if (!ract) begin
            if (ser == 1'b0) begin
                ract <= 1'b1;
                rcnt <= 0;
            end
        end else begin
            rcnt <= rcnt + 1;
            if (rcnt >= 4 && rcnt <= 32 && (rcnt % 4) == 0) rsh <= {ser, rsh[7:1]};
            if (rcnt == 34) begin
                rxq.push_back(rsh);
                ract <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at posedge+1, check at posedge+2, update the reference.
    task automatic step(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        output logic [1:0] acc);
        logic [1:0] eg;
        logic [7:0] b;
        req_valid = v;
        req_data  = {d1, d0};
        #1;
        eg = 2'b00;
        if (v == 2'b01)      eg = 2'b01;
        else if (v == 2'b10) eg = 2'b10;
        else if (v == 2'b11) eg = (mlast == 1) ? 2'b01 : 2'b10;
        if (expq.size() >= DEPTH && !tx_en) eg = 2'b00;
        check("level", 32'(level), 32'(expq.size()));
        check("ready", 32'(ready), 32'(eg));
`ifndef UART_TX_SCHED_TIMEOUT_EN
        check("err_tied_low", 32'(err), 32'd0);
`endif
        if (tx_en) begin
            if (expq.size() == 0) begin
                check("launch_with_empty_queue", 32'(tx_en), 32'd0);
            end else begin
                b = expq.pop_front();
                check("tx_data", 32'(tx_data), 32'(b));
            end
        end
        if (eg[0]) begin
            expq.push_back(d0);
            mlast = 0;
        end else if (eg[1]) begin
            expq.push_back(d1);
            mlast = 1;
        end
        acc = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        req_valid = '0;
        req_data  = '0;
        man_done  = 1'b0;
        rst_n     = 1'b0;
        repeat (50) @(posedge clk);
        #1 rst_n = 1'b1;
        expq.delete();
        mlast = 1;
    endtask

    initial begin
        logic [1:0] acc;
        logic [7:0] s0, s1, b;
        logic [7:0] sent[$];
        int lowcnt, l0, rx0, i, lc, ec, nc, ecnt;

        // Reset state and first-grant priority.
        reset_dut();
        check("rst_level", 32'(level), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        req_valid = 2'b11;
        #1 check("rst_first_grant_req0", 32'(ready), 32'b01);
        req_valid = 2'b00;
        @(posedge clk);
        #1;

        // Single byte with exact launch latency and busy until done edge.
        model_en = 1'b1;
        rx0 = rxq.size();
        step(2'b01, 8'hA5, 8'($urandom), acc);
        check("lat_cycle1_tx_en", 32'(tx_en), 32'd0);
        check("lat_cycle1_busy", 32'(busy), 32'd1);
        step(2'b00, 8'h00, 8'h00, acc);
        check("lat_cycle2_tx_en", 32'(tx_en), 32'd1);
        check("lat_cycle2_tx_data", 32'(tx_data), 32'hA5);
        lowcnt = 0;
        for (i = 0; i < 200 && !tx_done; i++) begin
            if (!busy) lowcnt++;
            step(2'b00, 8'h00, 8'h00, acc);
        end
        check("single_done_seen", 32'(tx_done), 32'd1);
        check("single_busy_low_before_done", 32'(lowcnt), 32'd0);
        check("single_tx_data_held", 32'(tx_data), 32'hA5);
        step(2'b00, 8'h00, 8'h00, acc);
        check("single_busy_after_done", 32'(busy), 32'd0);
        check("single_rx_count", 32'(rxq.size() - rx0), 32'd1);
        if (rxq.size() > rx0) check("single_rx_byte", 32'(rxq[rx0]), 32'hA5);

        // Fairness and full FIFO with done held low.
        reset_dut();
        model_en = 1'b0;
        s0 = 8'h10;
        s1 = 8'h20;
        l0 = launches;
        for (int k = 0; k < 12; k++) begin
            step(2'b11, s0, s1, acc);
            if (acc[0]) s0++;
            if (acc[1]) s1++;
        end
        check("full_launched_first", 32'(tx_data), 32'h10);
        check("full_level", 32'(level), 32'd8);
        check("full_ready_low", 32'(ready), 32'd0);
        check("full_stream0_next", 32'(s0), 32'h15);
        check("full_stream1_next", 32'(s1), 32'h24);
        man_done = 1'b1;
        step(2'b11, s0, s1, acc);
        if (acc[0]) s0++;
        if (acc[1]) s1++;
        step(2'b11, s0, s1, acc);
        if (acc[0]) s0++;
        if (acc[1]) s1++;
        man_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(2'b11, s0, s1, acc);
            if (acc[0]) s0++;
            if (acc[1]) s1++;
        end
        check("full_relaunch_count", 32'(launches - l0), 32'd2);
        check("full_relaunch_byte", 32'(tx_data), 32'h20);
        check("full_refilled_level", 32'(level), 32'd8);

        // Three queued bytes with a 2-cycle done level per frame.
        reset_dut();
        model_en = 1'b1;
        sent.delete();
        rx0 = rxq.size();
        l0 = launches;
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            step((k == 1) ? 2'b10 : 2'b01, b, b, acc);
            sent.push_back(b);
        end
        for (i = 0; i < 1000 && busy; i++) step(2'b00, 8'h00, 8'h00, acc);
        check("three_drained", 32'(busy), 32'd0);
        check("three_launches", 32'(launches - l0), 32'd3);
        check("three_rx_count", 32'(rxq.size() - rx0), 32'd3);
        for (int k = 0; k < 3 && (rx0 + k) < rxq.size(); k++)
            check("three_rx_order", 32'(rxq[rx0 + k]), 32'(sent[k]));

        // Random traffic on both requesters, drained through the UART model.
        sent.delete();
        rx0 = rxq.size();
        l0 = launches;
        for (int k = 0; k < 60; k++) begin
            s0 = 8'($urandom);
            s1 = 8'($urandom);
            step(2'($urandom_range(0, 3)), s0, s1, acc);
            if (acc[0]) sent.push_back(s0);
            if (acc[1]) sent.push_back(s1);
        end
        for (i = 0; i < 5000 && busy; i++) step(2'b00, 8'h00, 8'h00, acc);
        check("rand_drained", 32'(busy), 32'd0);
        check("rand_launches", 32'(launches - l0), 32'(sent.size()));
        check("rand_rx_count", 32'(rxq.size() - rx0), 32'(sent.size()));
        for (int k = 0; k < sent.size() && (rx0 + k) < rxq.size(); k++)
            check("rand_rx_order", 32'(rxq[rx0 + k]), 32'(sent[k]));

        // Reset asserted mid-frame discards queued bytes.
        reset_dut();
        model_en = 1'b0;
        for (int k = 0; k < 5; k++) step(2'b01, 8'($urandom), 8'h00, acc);
        for (int k = 0; k < 3; k++) step(2'b00, 8'h00, 8'h00, acc);
        check("midrst_queued", 32'(level), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_tx_en", 32'(tx_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expq.delete();
        mlast = 1;
        l0 = launches;
        for (int k = 0; k < 10; k++) step(2'b00, 8'h00, 8'h00, acc);
        check("midrst_no_launch", 32'(launches - l0), 32'd0);
        b = 8'($urandom);
        step(2'b01, b, 8'h00, acc);
        step(2'b00, 8'h00, 8'h00, acc);
        check("midrst_new_launch", 32'(tx_en), 32'd1);
        check("midrst_new_byte", 32'(tx_data), 32'(b));

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Missing done edge times out and the next byte launches.
        reset_dut();
        model_en = 1'b0;
        step(2'b01, 8'($urandom), 8'h00, acc);
        step(2'b01, 8'($urandom), 8'h00, acc);
        lc = -1;
        ec = -1;
        nc = -1;
        ecnt = 0;
        for (i = 0; i < 150; i++) begin
            if (tx_en && lc < 0) lc = i;
            else if (tx_en && ec >= 0 && nc < 0) nc = i;
            if (err) begin
                ecnt++;
                if (ec < 0) ec = i;
            end
            step(2'b00, 8'h00, 8'h00, acc);
        end
        check("timeout_after_launch", 32'(ec - lc), 32'd100);
        check("timeout_relaunch", 32'(nc - ec), 32'd2);
        check("timeout_pulse_width", 32'(ecnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
